// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state encodings, control codes and state-to-control decode for mc_control_seq
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST      = 5'd0,
    S_FETCH    = 5'd1,
    S_LATCH    = 5'd2,
    S_DECODE   = 5'd3,
    S_ADD      = 5'd4,
    S_SUB      = 5'd5,
    S_AND      = 5'd6,
    S_WB       = 5'd7,
    S_MD_START = 5'd8,
    S_MD_WAIT  = 5'd9,
    S_MD_WRITE = 5'd10,
    S_EXC_EPC  = 5'd11,
    S_EXC_READ = 5'd12,
    S_EXC_LOAD = 5'd13,
    S_EXC_JUMP = 5'd14
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;
  localparam logic [2:0] PCSRC_ALU = 3'b001, PCSRC_MDR = 3'b011;
  localparam logic [2:0] MADR_PC = 3'b000, MADR_OVF = 3'b011, MADR_OPC = 3'b100, MADR_DIV = 3'b101;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_MULT = 6'h18, FN_DIV = 6'h1A;
  localparam logic [2:0] CAUSE_NONE = 3'd0, CAUSE_OVF = 3'd1, CAUSE_OPC = 3'd2,
                         CAUSE_DIV0 = 3'd3, CAUSE_TMO = 3'd4;

  typedef struct packed {
    logic       pc_write, ir_write, reg_write, a_write, b_write, alu_out_write;
    logic       epc_write, md_write, mem_wr_rd, divor_mult, write_hi, write_lo;
    logic [2:0] pc_source, mem_adrs_src;
    logic [1:0] md_control, write_in;
    logic [2:0] write_data_src, alu_control;
    logic [1:0] alu_src_a, alu_src_b, mult, div;
  } ctrl_t;

  function automatic logic [2:0] cause_vector(input logic [2:0] cause);
    case (cause)
      CAUSE_OVF:            return MADR_OVF;
      CAUSE_OPC:            return MADR_OPC;
      CAUSE_DIV0, CAUSE_TMO: return MADR_DIV;
      default:              return MADR_PC;
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input state_e s, input logic [2:0] cause, input logic is_div);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.alu_src_b = 2'b01; c.alu_control = ALU_ADD; end
      S_LATCH:    begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.pc_source = PCSRC_ALU; end
      S_DECODE:   begin
        c.a_write = 1'b1; c.b_write = 1'b1; c.alu_out_write = 1'b1;
        c.alu_src_b = 2'b11; c.alu_control = ALU_ADD;
      end
      S_ADD:      begin c.alu_src_a = 2'b01; c.alu_out_write = 1'b1; c.alu_control = ALU_ADD; end
      S_SUB:      begin c.alu_src_a = 2'b01; c.alu_out_write = 1'b1; c.alu_control = ALU_SUB; end
      S_AND:      begin c.alu_src_a = 2'b01; c.alu_out_write = 1'b1; c.alu_control = ALU_AND; end
      S_WB:       begin c.write_in = 2'b01; c.reg_write = 1'b1; end
      S_MD_START: begin
        c.divor_mult = is_div;
        if (is_div) c.div = 2'b01;
        else        c.mult = 2'b01;
      end
      S_MD_WAIT:  c.divor_mult = is_div;
      S_MD_WRITE: begin c.write_hi = 1'b1; c.write_lo = 1'b1; end
      S_EXC_EPC:  begin
        c.alu_src_b = 2'b01; c.alu_control = ALU_SUB; c.epc_write = 1'b1;
        c.mem_adrs_src = cause_vector(cause);
      end
      S_EXC_READ: c.mem_adrs_src = cause_vector(cause);
      S_EXC_LOAD: begin c.md_write = 1'b1; c.md_control = 2'b10; end
      S_EXC_JUMP: begin c.pc_write = 1'b1; c.pc_source = PCSRC_MDR; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// rtl/ctrl_wait_counter.sv - clearable up-counter saturating at a terminal count
module ctrl_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)            cnt_q <= '0;
    else if (en_i && cnt_q != tc_i) cnt_q <= cnt_q + 1'b1;
  end

  assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/mc_control_seq.sv
// rtl/mc_control_seq.sv - multicycle control sequencer with wait states, exceptions and MULT/DIV handshake
module mc_control_seq
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT   = 1,
  parameter int MD_TIMEOUT = 34,
  parameter int EXC_ENABLE = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       o_i,
  input  logic       md_done_i,
  input  logic       div_zero_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       a_write_o,
  output logic       b_write_o,
  output logic       alu_out_write_o,
  output logic       epc_write_o,
  output logic       md_write_o,
  output logic       mem_wr_rd_o,
  output logic       divor_mult_o,
  output logic       write_hi_o,
  output logic       write_lo_o,
  output logic [2:0] pc_source_o,
  output logic [2:0] mem_adrs_src_o,
  output logic [1:0] md_control_o,
  output logic [1:0] write_in_o,
  output logic [2:0] write_data_src_o,
  output logic [2:0] alu_control_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] mult_o,
  output logic [1:0] div_o,
  output logic [2:0] exc_cause_o,
  output logic [4:0] state_dbg_o
);

  localparam int              MW_W   = $clog2(MEM_WAIT + 1) + 1;
  localparam logic [MW_W-1:0] MEM_TC = MW_W'(MEM_WAIT);
  localparam logic [7:0]      MD_TC  = 8'(MD_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] cause_q, cause_d;
  logic       is_div_q, is_div_d;
  ctrl_t      ctrl_q;
  logic       state_chg, mem_done, md_tmo;

  assign state_chg = (state_d != state_q);

  ctrl_wait_counter #(.W(MW_W)) u_mem_wait (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (state_chg),
    .en_i  (state_q == S_FETCH || state_q == S_EXC_READ),
    .tc_i  (MEM_TC), .done_o (mem_done)
  );

  ctrl_wait_counter #(.W(8)) u_md_timeout (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (state_chg),
    .en_i  (state_q == S_MD_WAIT),
    .tc_i  (MD_TC), .done_o (md_tmo)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    is_div_d = is_div_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    if (mem_done) state_d = S_LATCH;
      S_LATCH:    state_d = S_DECODE;
      S_DECODE: begin
        is_div_d = 1'b0;
        if (opcode_i != 6'd0) begin
          state_d = S_EXC_EPC; cause_d = CAUSE_OPC;
        end else begin
          case (funct_i)
            FN_ADD:  state_d = S_ADD;
            FN_SUB:  state_d = S_SUB;
            FN_AND:  state_d = S_AND;
            FN_MULT: state_d = S_MD_START;
            FN_DIV:  begin state_d = S_MD_START; is_div_d = 1'b1; end
            default: begin state_d = S_EXC_EPC; cause_d = CAUSE_OPC; end
          endcase
        end
      end
      S_ADD, S_SUB: begin
        if (o_i && EXC_ENABLE != 0) begin
          state_d = S_EXC_EPC; cause_d = CAUSE_OVF;
        end else begin
          state_d = S_WB;
        end
      end
      S_AND:      state_d = S_WB;
      S_WB:       state_d = S_FETCH;
      S_MD_START: state_d = S_MD_WAIT;
      // divisor-zero beats done, and done beats a timeout landing on the same cycle
      S_MD_WAIT: begin
        if (div_zero_i)     begin state_d = S_EXC_EPC; cause_d = CAUSE_DIV0; end
        else if (md_done_i) state_d = S_MD_WRITE;
        else if (md_tmo)    begin state_d = S_EXC_EPC; cause_d = CAUSE_TMO; end
      end
      S_MD_WRITE: state_d = S_FETCH;
      S_EXC_EPC:  state_d = S_EXC_READ;
      S_EXC_READ: if (mem_done) state_d = S_EXC_LOAD;
      S_EXC_LOAD: state_d = S_EXC_JUMP;
      S_EXC_JUMP: state_d = S_FETCH;
      default:    state_d = S_RST;
    endcase
  end

  // Outputs are registered from the next-state decode so they stay a pure function of state_q
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_RST;
      cause_q  <= CAUSE_NONE;
      is_div_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      is_div_q <= is_div_d;
      ctrl_q   <= decode_ctrl(state_d, cause_d, is_div_d);
    end
  end

  assign pc_write_o       = ctrl_q.pc_write;
  assign ir_write_o       = ctrl_q.ir_write;
  assign reg_write_o      = ctrl_q.reg_write;
  assign a_write_o        = ctrl_q.a_write;
  assign b_write_o        = ctrl_q.b_write;
  assign alu_out_write_o  = ctrl_q.alu_out_write;
  assign epc_write_o      = ctrl_q.epc_write;
  assign md_write_o       = ctrl_q.md_write;
  assign mem_wr_rd_o      = ctrl_q.mem_wr_rd;
  assign divor_mult_o     = ctrl_q.divor_mult;
  assign write_hi_o       = ctrl_q.write_hi;
  assign write_lo_o       = ctrl_q.write_lo;
  assign pc_source_o      = ctrl_q.pc_source;
  assign mem_adrs_src_o   = ctrl_q.mem_adrs_src;
  assign md_control_o     = ctrl_q.md_control;
  assign write_in_o       = ctrl_q.write_in;
  assign write_data_src_o = ctrl_q.write_data_src;
  assign alu_control_o    = ctrl_q.alu_control;
  assign alu_src_a_o      = ctrl_q.alu_src_a;
  assign alu_src_b_o      = ctrl_q.alu_src_b;
  assign mult_o           = ctrl_q.mult;
  assign div_o            = ctrl_q.div;
  assign exc_cause_o      = cause_q;
  assign state_dbg_o      = state_q;

endmodule
